countdown_timer: RTL and testbench
==================================

# countdown_timer

Memory-mapped 32-bit countdown timer on the CPU's data bus, behind the address bridge. It consumes the CPU's store traffic (address, write data, byte enables) and produces one interrupt line that feeds one `HWInt` bit of the CPU. It supports one-shot and auto-reload modes, with an interrupt mask and sticky or pulsed interrupt semantics.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `we`  in  1  bus write strobe, already decoded by the bridge for this device
- `byteen`  in  4  per-byte write mask; bit i enables `wdata[8i+7:8i]`
- `addr`  in  32  byte address; only `addr[3:2]` is decoded
- `wdata`  in  32  store data
- `rdata`  out  32  combinational read data for `addr[3:2]`
- `irq`  out  1  interrupt request, equal to `CTRL.IM & pending`

## Operation
- Register map, selected by `addr[3:2]`:
  - 0 = CTRL, read/write.
  - 1 = PRESET, read/write.
  - 2 = COUNT, read-only; writes are ignored.
  - 3 reads as 0; writes are ignored.
- CTRL fields; unimplemented bits read 0:
  - bit0 EN
  - bits[2:1] MODE: 00 one-shot, 01 auto-reload, 1x behaves as 00
  - bit3 IM
- Writes merge per byte under `byteen`; bytes that are not enabled keep their value. `byteen==0` with `we` is a no-op.
- Any write to CTRL, with any nonzero `byteen`, clears `pending`.
- FSM states and transitions (each transition is one clock edge):
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If !EN, go to IDLE; COUNT holds.
    - Else if COUNT > 1, COUNT <= COUNT-1.
    - Else (COUNT is 0 or 1), COUNT <= 0, `pending` <= 1, go to INT.
  - INT in MODE 00: EN <= 0; go to IDLE; `pending` stays set until software writes CTRL.
  - INT in MODE 01: go to LOAD; `pending` <= 0. The result is a one-cycle `irq` pulse per period.
- Writing PRESET never affects a count in progress; the new value is used at the next LOAD.
- Clearing EN, then setting it again, always reloads from PRESET. The count does not resume.

## Timing
- Reset values:
  - CTRL, PRESET and COUNT are 0.
  - State is IDLE.
  - `pending` is 0 and `irq` is 0.
  - `rdata` is 0 for every address.
- `rdata` is combinational from the current register contents. A read in the same cycle as a write returns the old value.
- A bus write is registered on edge t. The FSM acts on the new CTRL value at edge t+1.
- Latency from the edge that sets EN to the first `irq` is PRESET+2 edges for PRESET≥1. PRESET=0 behaves like PRESET=1 (3 edges).
- Auto-reload period is PRESET+2 cycles. `irq` is high for exactly 1 cycle per period.
- Collision in INT, MODE 00: if the bus writes CTRL with EN=1 on the same edge, the bus value wins. EN stays 1, `pending` clears, and the FSM goes to IDLE, then LOAD.
- Collision in CNT: if the bus write and the terminal count land on the same edge, `pending` is set, because FSM set beats bus clear. The write still updates CTRL.
- `reset` asserted mid-count returns all state to reset values immediately, without waiting for a clock edge.
- Changing IM never alters `pending`; it masks `irq` combinationally.

## Test plan
- Reset/read-back:
  - Stimulus: assert `reset` mid-cycle, then read addresses 0x0, 0x4, 0x8 and 0xC.
  - Required: all reads return 0 and `irq`=0. Write 0xFFFFFFFF to CTRL, then CTRL reads 0x0000000F.
- One-shot:
  - Stimulus: PRESET=5, then CTRL=0x9 (EN, IM, MODE 00).
  - Required: `irq` rises 7 edges after the CTRL write and stays high. CTRL.EN reads 0 and COUNT reads 0.
  - Then write CTRL=0x8: `irq` falls the next cycle.
- Auto-reload:
  - Stimulus: PRESET=3, CTRL=0xB.
  - Required: the first `irq` pulse comes 5 edges after the write. Later pulses repeat every 5 cycles, each exactly 1 cycle wide. Sampled COUNT follows the sequence 3,2,1,0.
- Byte-enable merge:
  - Stimulus: PRESET=0x11223344, then write 0xAABBCCDD to PRESET with `byteen`=0101.
  - Required: PRESET reads 0x11BB33DD. A write to COUNT leaves COUNT unchanged.
- Disable mid-count:
  - Stimulus: PRESET=100, enable, wait 10 cycles, then write CTRL=0x8.
  - Required: COUNT freezes and `irq` never asserts.
  - Then write CTRL=0x9: COUNT reloads to 100.
- Masking and collision:
  - Stimulus: one-shot with IM=0.
  - Required: `irq`=0 while `pending` is set.
  - Then write CTRL=0x8 on the terminal-count edge: `irq` is high after that edge.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer
//   Memory-mapped 32-bit countdown timer with one-shot and auto-reload modes,
//   a maskable interrupt, and sticky (one-shot) or pulsed (auto-reload)
//   interrupt behaviour.
//
//   Register map (addr[3:2]):
//     0 CTRL   r/w  bit0 EN, bits[2:1] MODE (01 auto-reload, else one-shot), bit3 IM
//     1 PRESET r/w
//     2 COUNT  r/o
//     3 reads 0
//
//   Ports:
//     clk     single clock, rising edge
//     reset   asynchronous, active-high reset
//     we      bus write strobe (already decoded for this device)
//     byteen  per-byte write mask
//     addr    byte address, only addr[3:2] decoded
//     wdata   store data
//     rdata   combinational read data
//     irq     interrupt request = CTRL.IM & pending
//
//   state  | meaning
//   -------+-------------------------------------------------------
//   IDLE   | waiting for EN
//   LOAD   | COUNT <= PRESET on the next edge
//   CNT    | decrementing; terminal count raises pending
//   INT    | one-shot: clear EN and stop; auto-reload: drop pending, reload
module countdown_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [3:0]  ctrl;
    logic [3:0]  ctrl_next;
    logic [31:0] preset;
    logic [31:0] preset_next;
    logic [31:0] count;
    logic [31:0] count_next;
    logic        pending;

    logic        set_pending;
    logic        clr_pending_fsm;
    logic        clr_en;

    logic        en;
    logic        auto_reload;
    logic        im;
    logic        wr_ctrl;
    logic        wr_preset;

    // Address bits outside [3:2] are intentionally ignored.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

    assign en          = ctrl[0];
    assign auto_reload = (ctrl[2:1] == 2'b01);
    assign im          = ctrl[3];

    assign wr_ctrl   = we && (byteen != 4'd0) && (addr[3:2] == 2'd0);
    assign wr_preset = we && (byteen != 4'd0) && (addr[3:2] == 2'd1);

    assign irq = im & pending;

    always_comb begin
        rdata = 32'd0;
        case (addr[3:2])
            2'd0:    rdata = {28'd0, ctrl};
            2'd1:    rdata = preset;
            2'd2:    rdata = count;
            default: rdata = 32'd0;
        endcase
    end

    always_comb begin
        state_next      = state;
        count_next      = count;
        set_pending     = 1'b0;
        clr_pending_fsm = 1'b0;
        clr_en          = 1'b0;
        case (state)
            S_IDLE: begin
                if (en) state_next = S_LOAD;
            end
            S_LOAD: begin
                count_next = preset;
                state_next = S_CNT;
            end
            S_CNT: begin
                if (!en) begin
                    state_next = S_IDLE;
                end else if (count > 32'd1) begin
                    count_next = count - 32'd1;
                end else begin
                    // PRESET of 0 lands here too, so it behaves like 1.
                    count_next  = 32'd0;
                    set_pending = 1'b1;
                    state_next  = S_INT;
                end
            end
            S_INT: begin
                if (auto_reload) begin
                    clr_pending_fsm = 1'b1;
                    state_next      = S_LOAD;
                end else begin
                    clr_en     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // FSM's EN clear is applied first so a same-edge bus write to CTRL wins.
    always_comb begin
        ctrl_next = ctrl;
        if (clr_en) ctrl_next[0] = 1'b0;
        if (wr_ctrl && byteen[0]) ctrl_next = wdata[3:0];
    end

    always_comb begin
        preset_next = preset;
        for (int i = 0; i < 4; i++) begin
            if (wr_preset && byteen[i]) preset_next[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            ctrl    <= 4'd0;
            preset  <= 32'd0;
            count   <= 32'd0;
            pending <= 1'b0;
        end else begin
            state  <= state_next;
            ctrl   <= ctrl_next;
            preset <= preset_next;
            count  <= count_next;
            // Terminal count beats a same-edge software clear.
            if (set_pending)
                pending <= 1'b1;
            else if (wr_ctrl || clr_pending_fsm)
                pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
//   Directed bench for countdown_timer. A behavioural model tracks how many
//   edges have elapsed since the current run started and derives COUNT and
//   the terminal edge arithmetically from the latched preset.
module tb_countdown_timer;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        we     = 1'b0;
    logic [3:0]  byteen = 4'd0;
    logic [31:0] addr   = 32'h8;
    logic [31:0] wdata  = 32'd0;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    countdown_timer dut (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .byteen (byteen),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0]  m_ctrl    = 4'd0;
    logic [31:0] m_preset  = 32'd0;
    logic [31:0] m_count   = 32'd0;
    logic        m_pending = 1'b0;
    bit          m_run     = 1'b0;
    longint      m_p       = 0;   // edges since run start
    longint      m_len     = 0;   // preset latched for this period
    longint      m_term    = 0;   // edge index of terminal count
    bit          m_wr_ctrl, m_wr_pre, m_set_p, m_clr_p, m_clr_en;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ctrl    = 4'd0;
            m_preset  = 32'd0;
            m_count   = 32'd0;
            m_pending = 1'b0;
            m_run     = 1'b0;
            m_p       = 0;
        end else begin
            m_wr_ctrl = we && (byteen != 4'd0) && (addr[3:2] == 2'd0);
            m_wr_pre  = we && (byteen != 4'd0) && (addr[3:2] == 2'd1);
            m_set_p   = 1'b0;
            m_clr_p   = 1'b0;
            m_clr_en  = 1'b0;
            if (!m_run) begin
                if (m_ctrl[0]) begin
                    m_run = 1'b1;
                    m_p   = 1;
                end
            end else if (m_p == 1) begin
                m_len   = longint'(m_preset);
                m_term  = ((m_len == 0) ? 1 : m_len) + 2;
                m_p     = 2;
                m_count = m_preset;
            end else if (m_p == m_term) begin
                if (m_ctrl[2:1] == 2'b01) begin
                    m_p     = 1;
                    m_clr_p = 1'b1;
                end else begin
                    m_run    = 1'b0;
                    m_clr_en = 1'b1;
                end
            end else if (!m_ctrl[0]) begin
                m_run = 1'b0;
            end else begin
                m_p = m_p + 1;
                if (m_p == m_term) begin
                    m_count = 32'd0;
                    m_set_p = 1'b1;
                end else begin
                    m_count = 32'(m_len - (m_p - 2));
                end
            end
            if (m_set_p)
                m_pending = 1'b1;
            else if (m_wr_ctrl || m_clr_p)
                m_pending = 1'b0;
            if (m_clr_en) m_ctrl[0] = 1'b0;
            if (m_wr_ctrl && byteen[0]) m_ctrl = wdata[3:0];
            for (int i = 0; i < 4; i++)
                if (m_wr_pre && byteen[i]) m_preset[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    function automatic logic [31:0] m_rd(input logic [1:0] sel);
        case (sel)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        check("irq_vs_model", {31'd0, irq}, {31'd0, m_ctrl[3] & m_pending});
        check("rdata_vs_model", rdata, m_rd(addr[3:2]));
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr   = a;
        wdata  = d;
        byteen = be;
        we     = 1'b1;
        @(posedge clk);
        #2;
        we     = 1'b0;
        byteen = 4'd0;
        addr   = 32'h8;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
        @(posedge clk);
        #2;
        addr = 32'h8;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;

        // reset mid-count
        bus_write(32'h4, 32'd50, 4'hF);
        bus_write(32'h0, 32'h9, 4'hF);
        step(6);
        #1 reset = 1'b1;
        #1;
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_count_async", rdata, 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        bus_read(32'h0, v);  check("reset_rd_ctrl", v, 32'd0);
        bus_read(32'h4, v);  check("reset_rd_preset", v, 32'd0);
        bus_read(32'h8, v);  check("reset_rd_count", v, 32'd0);
        bus_read(32'hC, v);  check("reset_rd_c", v, 32'd0);
        check("reset_irq_after", {31'd0, irq}, 32'd0);
        bus_write(32'h0, 32'hFFFF_FFFF, 4'hF);
        bus_read(32'h0, v);  check("ctrl_all_ones", v, 32'h0000_000F);
        bus_write(32'h0, 32'h0, 4'hF);
        step(3);

        // one-shot, PRESET=5
        bus_write(32'h4, 32'd5, 4'hF);
        bus_write(32'h0, 32'h9, 4'hF);
        step(2);  check("os_count_load", rdata, 32'd5);
        step(4);  check("os_irq_t6", {31'd0, irq}, 32'd0);
                  check("os_count_t6", rdata, 32'd1);
        step(1);  check("os_irq_t7", {31'd0, irq}, 32'd1);
                  check("os_count_t7", rdata, 32'd0);
        step(3);  check("os_irq_sticky", {31'd0, irq}, 32'd1);
        bus_read(32'h0, v);  check("os_ctrl_en_clear", v, 32'h8);
        bus_read(32'h8, v);  check("os_count_zero", v, 32'd0);
        bus_write(32'h0, 32'h8, 4'hF);
        check("os_irq_cleared", {31'd0, irq}, 32'd0);
        step(2);

        // auto-reload, PRESET=3
        bus_write(32'h4, 32'd3, 4'hF);
        bus_write(32'h0, 32'hB, 4'hF);
        step(2);  check("ar_count_3", rdata, 32'd3);
        step(1);  check("ar_count_2", rdata, 32'd2);
        step(1);  check("ar_count_1", rdata, 32'd1);
                  check("ar_irq_t4", {31'd0, irq}, 32'd0);
        step(1);  check("ar_count_0", rdata, 32'd0);
                  check("ar_irq_t5", {31'd0, irq}, 32'd1);
        step(1);  check("ar_irq_t6", {31'd0, irq}, 32'd0);
        step(4);  check("ar_irq_t10", {31'd0, irq}, 32'd1);
        step(1);  check("ar_irq_t11", {31'd0, irq}, 32'd0);
        step(4);  check("ar_irq_t15", {31'd0, irq}, 32'd1);
        bus_write(32'h0, 32'h0, 4'hF);
        step(4);

        // byte-enable merge
        bus_write(32'h4, 32'h1122_3344, 4'hF);
        bus_write(32'h4, 32'hAABB_CCDD, 4'b0101);
        bus_read(32'h4, v);  check("be_merge", v, 32'h11BB_33DD);
        bus_write(32'h4, 32'hFFFF_FFFF, 4'h0);
        bus_read(32'h4, v);  check("be_zero_noop", v, 32'h11BB_33DD);

        // disable mid-count, PRESET=100
        bus_write(32'h4, 32'd100, 4'hF);
        bus_write(32'h0, 32'h9, 4'hF);
        step(9);
        bus_write(32'h0, 32'h8, 4'hF);
        step(5);  check("dis_count_frozen", rdata, 32'd92);
                  check("dis_irq", {31'd0, irq}, 32'd0);
        bus_write(32'h8, 32'h55, 4'hF);
        step(1);  check("count_write_ignored", rdata, 32'd92);
        bus_write(32'hC, 32'h1234, 4'hF);
        bus_read(32'hC, v);  check("addr_c_zero", v, 32'd0);
        bus_write(32'h0, 32'h9, 4'hF);
        step(2);  check("reen_reload", rdata, 32'd100);
        bus_write(32'h0, 32'h0, 4'hF);
        step(3);

        // masked one-shot, PRESET=2
        bus_write(32'h4, 32'd2, 4'hF);
        bus_write(32'h0, 32'h1, 4'hF);
        step(5);  check("mask_irq_low", {31'd0, irq}, 32'd0);
        // terminal-count collision with a CTRL write
        bus_write(32'h0, 32'h1, 4'hF);
        step(3);
        bus_write(32'h0, 32'h8, 4'hF);
        check("coll_cnt_irq", {31'd0, irq}, 32'd1);
        step(2);  check("coll_cnt_irq_hold", {31'd0, irq}, 32'd1);
        bus_write(32'h0, 32'h0, 4'hF);
        step(1);

        // INT collision: software re-enables on the EN-clear edge
        bus_write(32'h4, 32'd1, 4'hF);
        bus_write(32'h0, 32'h9, 4'hF);
        step(3);
        bus_write(32'h0, 32'h9, 4'hF);
        check("coll_int_irq_clear", {31'd0, irq}, 32'd0);
        bus_read(32'h0, v);  check("coll_int_en_kept", v, 32'h9);
        step(1);  check("coll_int_irq_t6", {31'd0, irq}, 32'd0);
        step(1);  check("coll_int_irq_t7", {31'd0, irq}, 32'd1);
        bus_write(32'h0, 32'h0, 4'hF);
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
